// File: rtl/adder_acc_pkg.sv
// Shared types and arithmetic for the adder sum accumulator.
// sat_add works at a fixed maximum width; callers pass their real width and take the low bits.
package adder_acc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    HOLD
  } state_e;

  localparam int unsigned MAX_ACC_W = 64;

  // Returns {ovf, result}. Both inputs must already fit in acc_w bits.
  // On carry out of bit acc_w-1 the result clamps to all-ones.
  function automatic logic [MAX_ACC_W:0] sat_add(
    input logic [MAX_ACC_W-1:0] acc,
    input logic [MAX_ACC_W-1:0] sum,
    input logic [6:0]           acc_w
  );
    logic [MAX_ACC_W:0] full;
    logic [MAX_ACC_W:0] ones;
    full = {1'b0, acc} + {1'b0, sum};
    ones = ((MAX_ACC_W + 1)'(1) << acc_w) - (MAX_ACC_W + 1)'(1);
    if (full[acc_w]) begin
      return {1'b1, ones[MAX_ACC_W-1:0]};
    end
    return {1'b0, full[MAX_ACC_W-1:0]};
  endfunction

endpackage

// File: rtl/adder_sum_accumulator_if.sv
// Upstream sum handshake and downstream result handshake of the accumulator.
// The accumulator sits on the slave side; the producer/consumer pair drives the master side.
interface adder_sum_accumulator_if #(
  parameter int Width    = 8,
  parameter int AccWidth = 16,
  parameter int MaxLen   = 16
);
  localparam int LenWidth = $clog2(MaxLen + 1);

  logic [Width-1:0]    sum_i;
  logic                sum_valid_i;
  logic                sum_ready_o;
  logic [LenWidth-1:0] len_i;
  logic [AccWidth-1:0] acc_o;
  logic                acc_valid_o;
  logic                acc_ready_i;
  logic                ovf_o;
  logic [LenWidth-1:0] count_o;

  modport master (
    output sum_i, sum_valid_i, len_i, acc_ready_i,
    input  sum_ready_o, acc_o, acc_valid_o, ovf_o, count_o
  );

  modport slave (
    input  sum_i, sum_valid_i, len_i, acc_ready_i,
    output sum_ready_o, acc_o, acc_valid_o, ovf_o, count_o
  );
endinterface

// File: rtl/adder_sum_accumulator.sv
// Accumulates blocks of adder sums into a saturating register and hands each
// block total downstream with a sticky overflow flag.
module adder_sum_accumulator
  import adder_acc_pkg::*;
#(
  parameter int Width    = 8,
  parameter int AccWidth = 16,
  parameter int MaxLen   = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  adder_sum_accumulator_if.slave  bus
);
  localparam int LenWidth = $clog2(MaxLen + 1);

  state_e              state_q, state_d;
  logic [AccWidth-1:0] acc_q, acc_d;
  logic                ovf_q, ovf_d;
  logic [LenWidth-1:0] count_q, count_d;
  logic [LenWidth-1:0] len_q, len_d;
  logic                sum_ready_q, sum_ready_d;
  logic                acc_valid_q, acc_valid_d;

  logic                accept;
  logic                emit;
  logic [LenWidth-1:0] len_clamp;
  logic [LenWidth-1:0] count_inc;
  logic [MAX_ACC_W:0]  add_res;
  logic                add_unused;

  assign accept    = bus.sum_valid_i && sum_ready_q;
  assign emit      = acc_valid_q && bus.acc_ready_i;
  assign count_inc = count_q + LenWidth'(1);
  assign add_res   = sat_add(MAX_ACC_W'(acc_q), MAX_ACC_W'(bus.sum_i), 7'(AccWidth));
  assign add_unused = ^add_res;

  // A zero length still makes a one-sample block; oversize lengths clamp to MaxLen.
  always_comb begin
    len_clamp = bus.len_i;
    if (bus.len_i == '0) begin
      len_clamp = LenWidth'(1);
    end else if (bus.len_i > LenWidth'(MaxLen)) begin
      len_clamp = LenWidth'(MaxLen);
    end
  end

  // NOTE: every output of this block gets a default first, so no path leaves one unassigned (no latches).
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    count_d = count_q;
    len_d   = len_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          len_d   = len_clamp;
          acc_d   = AccWidth'(bus.sum_i);
          ovf_d   = 1'b0;
          count_d = LenWidth'(1);
          state_d = (len_clamp == LenWidth'(1)) ? HOLD : ACCUM;
        end
      end
      ACCUM: begin
        if (accept) begin
          acc_d   = add_res[AccWidth-1:0];
          ovf_d   = ovf_q | add_res[MAX_ACC_W];
          count_d = count_inc;
          if (count_inc == len_q) begin
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (emit) begin
          count_d = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    sum_ready_d = (state_d != HOLD);
    acc_valid_d = (state_d == HOLD);
  end

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      count_q     <= '0;
      len_q       <= LenWidth'(1);
      sum_ready_q <= 1'b1;
      acc_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
      count_q     <= count_d;
      len_q       <= len_d;
      sum_ready_q <= sum_ready_d;
      acc_valid_q <= acc_valid_d;
    end
  end

  assign bus.sum_ready_o = sum_ready_q;
  assign bus.acc_valid_o = acc_valid_q;
  assign bus.acc_o       = acc_q;
  assign bus.ovf_o       = ovf_q;
  assign bus.count_o     = count_q;

endmodule

// File: tb/tb_adder_sum_accumulator.sv
// Directed bench for adder_sum_accumulator: a 16-bit and an 8-bit accumulator
// share one stimulus stream and are checked against hand-computed values.
module tb_adder_sum_accumulator;
  logic       clk;
  logic       rst;
  logic [7:0] sum;
  logic       sum_valid;
  logic [4:0] len;
  logic       acc_ready;

  int checks   = 0;
  int failures = 0;

  adder_sum_accumulator_if #(.Width(8), .AccWidth(16), .MaxLen(16)) bus16 ();
  adder_sum_accumulator_if #(.Width(8), .AccWidth(8),  .MaxLen(16)) bus8 ();

  assign bus16.sum_i       = sum;
  assign bus16.sum_valid_i = sum_valid;
  assign bus16.len_i       = len;
  assign bus16.acc_ready_i = acc_ready;
  assign bus8.sum_i        = sum;
  assign bus8.sum_valid_i  = sum_valid;
  assign bus8.len_i        = len;
  assign bus8.acc_ready_i  = acc_ready;

  adder_sum_accumulator #(.Width(8), .AccWidth(16), .MaxLen(16)) dut16 (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus16)
  );

  adder_sum_accumulator #(.Width(8), .AccWidth(8), .MaxLen(16)) dut8 (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock edge and settle 1ns past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_hold16(input string name, input int exp_acc, input int exp_cnt);
    checks++;
    if (bus16.acc_valid_o !== 1'b1 || bus16.sum_ready_o !== 1'b0 ||
        bus16.acc_o !== 16'(exp_acc) || bus16.count_o !== 5'(exp_cnt)) begin
      failures++;
      $display("FAIL %s got valid=%0b ready=%0b acc=%0d cnt=%0d exp valid=1 ready=0 acc=%0d cnt=%0d",
               name, bus16.acc_valid_o, bus16.sum_ready_o, bus16.acc_o, bus16.count_o,
               exp_acc, exp_cnt);
    end
  endtask

  task automatic check_idle16(input string name, input int exp_acc);
    checks++;
    if (bus16.acc_valid_o !== 1'b0 || bus16.sum_ready_o !== 1'b1 ||
        bus16.acc_o !== 16'(exp_acc) || bus16.count_o !== 5'd0) begin
      failures++;
      $display("FAIL %s got valid=%0b ready=%0b acc=%0d cnt=%0d exp valid=0 ready=1 acc=%0d cnt=0",
               name, bus16.acc_valid_o, bus16.sum_ready_o, bus16.acc_o, bus16.count_o, exp_acc);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; sum = '0; sum_valid = 1'b0; len = '0; acc_ready = 1'b0;
    #12;
    check_idle16("reset_dut16", 0);
    checks++;
    if (bus8.acc_o !== 8'd0 || bus8.ovf_o !== 1'b0 || bus8.sum_ready_o !== 1'b1 ||
        bus8.acc_valid_o !== 1'b0 || bus16.ovf_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_dut8 got acc=%0d ovf=%0b ready=%0b valid=%0b exp acc=0 ovf=0 ready=1 valid=0",
               bus8.acc_o, bus8.ovf_o, bus8.sum_ready_o, bus8.acc_valid_o);
    end
    @(negedge clk);
    rst = 1'b0;
    step();
  endtask

  task automatic test_basic_block();
    int vals[4] = '{10, 20, 30, 40};
    len = 5'd4; acc_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sum = 8'(vals[i]); sum_valid = 1'b1;
      step();
      if (i == 2) begin
        checks++;
        if (bus16.acc_valid_o !== 1'b0 || bus16.count_o !== 5'd3 || bus16.acc_o !== 16'd60) begin
          failures++;
          $display("FAIL basic_mid got valid=%0b cnt=%0d acc=%0d exp valid=0 cnt=3 acc=60",
                   bus16.acc_valid_o, bus16.count_o, bus16.acc_o);
        end
      end
    end
    sum_valid = 1'b0;
    check_hold16("basic_result", 100, 4);
    checks++;
    if (bus16.ovf_o !== 1'b0) begin
      failures++;
      $display("FAIL basic_ovf got=%0b exp=0", bus16.ovf_o);
    end
    step();
    check_idle16("basic_emit", 100);
  endtask

  task automatic test_saturate();
    int vals[3] = '{200, 100, 50};
    len = 5'd3; acc_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sum = 8'(vals[i]); sum_valid = 1'b1;
      step();
    end
    sum_valid = 1'b0;
    checks++;
    if (bus8.acc_o !== 8'd255 || bus8.ovf_o !== 1'b1 || bus8.acc_valid_o !== 1'b1) begin
      failures++;
      $display("FAIL sat_dut8 got acc=%0d ovf=%0b valid=%0b exp acc=255 ovf=1 valid=1",
               bus8.acc_o, bus8.ovf_o, bus8.acc_valid_o);
    end
    check_hold16("sat_dut16_wide", 350, 3);
    checks++;
    if (bus16.ovf_o !== 1'b0) begin
      failures++;
      $display("FAIL sat_dut16_ovf got=%0b exp=0", bus16.ovf_o);
    end
    acc_ready = 1'b1;
    step();
    // New block clears the sticky flag.
    len = 5'd2;
    sum = 8'd1; sum_valid = 1'b1; step();
    sum = 8'd2; step();
    sum_valid = 1'b0;
    checks++;
    if (bus8.acc_o !== 8'd3 || bus8.ovf_o !== 1'b0 || bus8.acc_valid_o !== 1'b1) begin
      failures++;
      $display("FAIL sat_recover got acc=%0d ovf=%0b valid=%0b exp acc=3 ovf=0 valid=1",
               bus8.acc_o, bus8.ovf_o, bus8.acc_valid_o);
    end
    step();
    // Landing exactly on all-ones is not an overflow.
    sum = 8'd200; sum_valid = 1'b1; step();
    sum = 8'd55;  step();
    sum_valid = 1'b0;
    checks++;
    if (bus8.acc_o !== 8'd255 || bus8.ovf_o !== 1'b0) begin
      failures++;
      $display("FAIL sat_exact_ones got acc=%0d ovf=%0b exp acc=255 ovf=0", bus8.acc_o, bus8.ovf_o);
    end
    step();
  endtask

  task automatic test_len_edges();
    logic [4:0] lens[2] = '{5'd0, 5'd1};
    acc_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      len = lens[i]; sum = 8'd7; sum_valid = 1'b1;
      step();
      sum_valid = 1'b0;
      check_hold16($sformatf("len%0d_hold", i), 7, 1);
      acc_ready = 1'b1;
      step();
      acc_ready = 1'b0;
      check_idle16($sformatf("len%0d_emit", i), 7);
    end
    // Oversize length clamps to 16 samples.
    len = 5'd31; sum = 8'd1; sum_valid = 1'b1;
    for (int i = 0; i < 16; i++) step();
    sum_valid = 1'b0;
    check_hold16("len_clamp", 16, 16);
    acc_ready = 1'b1;
    step();
  endtask

  task automatic test_backpressure();
    len = 5'd2; acc_ready = 1'b0;
    sum = 8'd5; sum_valid = 1'b1; step();
    sum = 8'd6; step();
    for (int i = 0; i < 5; i++) begin
      sum = 8'd99; sum_valid = i[0];
      len = 5'd9;
      step();
      check_hold16($sformatf("bp_stall%0d", i), 11, 2);
    end
    sum_valid = 1'b0; acc_ready = 1'b1;
    step();
    check_idle16("bp_emit", 11);
  endtask

  task automatic test_toggle_valid();
    len = 5'd8; sum = 8'd3; acc_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      sum_valid = (i % 2 == 0);
      if (i == 4) len = 5'd2;
      step();
      checks++;
      if (bus16.count_o !== 5'(i / 2 + 1) || bus16.acc_o !== 16'(3 * (i / 2 + 1))) begin
        failures++;
        $display("FAIL toggle_step%0d got cnt=%0d acc=%0d exp cnt=%0d acc=%0d",
                 i, bus16.count_o, bus16.acc_o, i / 2 + 1, 3 * (i / 2 + 1));
      end
    end
    check_hold16("toggle_result", 24, 8);
    acc_ready = 1'b1;
    step();
  endtask

  task automatic test_async_reset();
    len = 5'd4; acc_ready = 1'b1;
    sum = 8'd50; sum_valid = 1'b1; step();
    sum = 8'd60; step();
    sum_valid = 1'b0;
    #3 rst = 1'b1;
    #1;
    check_idle16("async_reset_clear", 0);
    #1 rst = 1'b0;
    len = 5'd2;
    sum = 8'd9; sum_valid = 1'b1; step();
    step();
    sum_valid = 1'b0;
    check_hold16("post_reset_block", 18, 2);
    step();
    check_idle16("post_reset_emit", 18);
  endtask

  initial begin
    test_reset();
    test_basic_block();
    test_saturate();
    test_len_edges();
    test_backpressure();
    test_toggle_valid();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
